mul_tile_engine: RTL and testbench
==================================

# mul_tile_engine

Parametrised output-stationary N×N tile multiplier for the Frodo matrix datapath, the next generation of the fixed 4-lane multiply top. It consumes a stream of A columns and byte-packed secret rows, and accumulates the tile product in place. It then drains one result row per handshake, with optional per-row bias (error term) addition and mod-2^LOGQ reduction. Upstream sits the memory/address controller; downstream sits the BRAM writeback.

## Interface
- DATA_WIDTH, 16, lane width of A, bias, accumulators and results
- SYSTOLIC_WIDTH, 4, N: lanes per beat, tile is N×N
- KW, 16, width of the inner-dimension length counter
- LOGQ, 16, modulus exponent; results masked to LOGQ bits (LOGQ ≤ DATA_WIDTH)
- SECRET_SIGNED, 1, 1: secret bytes sign-extended; 0: zero-extended

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a tile; sampled only in IDLE
- k_len  in  KW  inner dimension, latched on start
- add_bias  in  1  latched on start; 1 = add bias stream during drain
- a_valid / a_ready  in / out  1  A beat handshake
- a_data  in  N*DATA_WIDTH  A column k; lane i at [i*DW +: DW]
- s_valid / s_ready  in / out  1  secret beat handshake
- s_data  in  N*8  secret row k; byte j at [j*8 +: 8]
- e_valid / e_ready  in / out  1  bias row handshake
- e_data  in  N*DATA_WIDTH  bias row, lane j
- out_valid / out_ready  out / in  1  result row handshake
- out_data  out  N*DATA_WIDTH  result row, lane j
- out_row  out  $clog2(N) (min 1)  index of the row in out_data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at tile end

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE, start=1: latch k_len and add_bias, clear all N² accumulators and the k counter, then go to ACCUM. If k_len=0, go straight to DRAIN.
- ACCUM: a_ready = s_ready = 1, and a beat fires only when a_valid && s_valid. Neither side is consumed alone.
- On a beat, for all i, j: acc[i][j] ← acc[i][j] + a_i * ext(s_j). ext is sign- or zero-extension to DATA_WIDTH. The product and sum are truncated mod 2^DATA_WIDTH.
- When the k_len-th beat fires, set row pointer r=0 and go to DRAIN.
- DRAIN uses a single output register. It loads when (!out_valid || out_ready) and (e_valid || !add_bias) and r < N.
  - Load value: out_data[j] = (acc[r][j] + (add_bias ? e_j : 0)) & (2^LOGQ−1).
  - On load: out_row ← r, r ← r+1, out_valid ← 1.
  - e_ready = add_bias && the load condition (combinational, this cycle).
- out_valid deasserts when out_ready is seen and no new load occurs.
- Final handshake of row N−1: go to IDLE, pulse done next cycle, out_valid returns to 0.
- start while busy: ignored. e_valid while not loading: ignored.
- Handshakes on a/s outside ACCUM and on e outside DRAIN: ready held 0.
- Reset (async, any state): state IDLE; all accumulators, counters and out_data 0; out_valid, done, a_ready, s_ready, e_ready, busy all 0; out_row 0.

## Timing
- The accumulator update is registered: the beat fired at edge t is visible at t+1.
- ACCUM→DRAIN on the edge of the last beat. The earliest out_valid is one cycle later.
- Throughput: one A/S beat per cycle; with out_ready=1 and e_valid=1, one row per cycle.
- Minimum tile latency, start to done: k_len + N + 2 cycles.
- out_data and out_row are stable while out_valid && !out_ready.
- A beat and the state change happen on the same edge, so there is no bubble between tiles except the IDLE cycle.

## Test plan
- N=4, DW=16, LOGQ=16, k_len=1, a=[1,2,3,4], s=[1,1,1,1], add_bias=0 -> rows 0..3 = {1,1,1,1}, {2,2,2,2}, {3,3,3,3}, {4,4,4,4}; done after 4 handshakes.
- SECRET_SIGNED=1, LOGQ=15, k_len=1, a lane0=5, s byte0=0xFF -> row0 lane0 = 0x7FFB. Same stimulus with SECRET_SIGNED=0 -> 0x04FB (1275).
- k_len=0, add_bias=1, e rows all 7 -> four rows {7,7,7,7}; a_ready never rises.
- Backpressure: k_len=2, out_ready low 3 cycles mid-drain, e_valid toggling -> out_data/out_row held stable, no row lost or duplicated, e_ready only on loads.
- Wrap: LOGQ=15, k_len=2, a lane0=0x7FFF both beats, s byte0=1 -> lane0 = 0x7FFE. Valids gapped (a_valid without s_valid) -> no accumulation on unpaired cycles.
- rst_n low mid-ACCUM after 1 of 3 beats -> all outputs 0 immediately; next tile with k_len=1, a=[2,0,0,0], s=[3,0,0,0] -> row0 lane0 = 6, no residue from the aborted tile.

Source files
------------

// File: rtl/mul_tile_engine.sv
// Output-stationary NxN tile multiplier: accumulates A-column x secret-row outer products,
// then drains one result row per handshake with optional bias addition and mod-2^LOGQ masking.
module mul_tile_engine #(
    parameter int DATA_WIDTH     = 16,
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int KW             = 16,
    parameter int LOGQ           = 16,
    parameter int SECRET_SIGNED  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [KW-1:0]                        k_len,
    input  logic                                 add_bias,
    input  logic                                 a_valid,
    output logic                                 a_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] a_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [SYSTOLIC_WIDTH*8-1:0]          s_data,
    input  logic                                 e_valid,
    output logic                                 e_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] e_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] out_data,
    output logic [((SYSTOLIC_WIDTH > 1) ? $clog2(SYSTOLIC_WIDTH) : 1)-1:0] out_row,
    output logic                                 busy,
    output logic                                 done
);
    localparam int N     = SYSTOLIC_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(N + 1);
    localparam logic [PTR_W-1:0] ROWS = PTR_W'(N);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k_len_q;
    logic [KW-1:0]    k_cnt;
    logic             bias_q;
    logic [PTR_W-1:0] row_ptr;
    logic [DW-1:0]    acc [N][N];
    logic [N*DW-1:0]  row_next;
    logic             beat;
    logic             last_beat;
    logic             load;
    logic             final_hs;

    function automatic logic [DW-1:0] ext_secret(input logic [7:0] b);
        logic [DW-1:0] r;
        r = (SECRET_SIGNED != 0) ? {{(DW-8){b[7]}}, b} : {{(DW-8){1'b0}}, b};
        return r;
    endfunction

    function automatic logic [DW-1:0] mod_q(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        for (int b = 0; b < DW; b++) r[b] = (b < LOGQ) ? x[b] : 1'b0;
        return r;
    endfunction

    assign busy      = (state != IDLE);
    assign a_ready   = (state == ACCUM);
    assign s_ready   = (state == ACCUM);
    assign beat      = (state == ACCUM) && a_valid && s_valid;
    assign last_beat = beat && (k_cnt == k_len_q - 1'b1);
    assign load      = (state == DRAIN) && (!out_valid || out_ready)
                       && (e_valid || !bias_q) && (row_ptr < ROWS);
    assign e_ready   = bias_q && load;
    assign final_hs  = (state == DRAIN) && (row_ptr == ROWS) && out_valid && out_ready;

    always_comb begin
        row_next = '0;
        for (int j = 0; j < N; j++) begin
            row_next[j*DW +: DW] = mod_q(acc[row_ptr[ROW_W-1:0]][j]
                                   + (bias_q ? e_data[j*DW +: DW] : {DW{1'b0}}));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_len_q   <= '0;
            k_cnt     <= '0;
            bias_q    <= 1'b0;
            row_ptr   <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            done      <= 1'b0;
        end else begin
            done <= final_hs;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_len_q <= k_len;
                        bias_q  <= add_bias;
                        k_cnt   <= '0;
                        row_ptr <= '0;
                        state   <= (k_len == '0) ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) k_cnt <= k_cnt + 1'b1;
                    if (last_beat) begin
                        row_ptr <= '0;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (load) begin
                        out_row   <= row_ptr[ROW_W-1:0];
                        row_ptr   <= row_ptr + 1'b1;
                        out_valid <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (final_hs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Product and sum wrap mod 2^DW, so the low bits are independent of operand signedness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    acc[i][j] <= '0;
        end else begin
            if (state == IDLE && start) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= '0;
            end else if (beat) begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= acc[i][j] + a_data[i*DW +: DW] * ext_secret(s_data[j*8 +: 8]);
            end
            if (load) out_data <= row_next;
        end
    end
endmodule

// File: tb/tb_mul_tile_engine.sv
// Bench for mul_tile_engine: two instances (signed secrets / LOGQ=15 and unsigned / LOGQ=16)
// share one stimulus stream; result rows are predicted into queues and popped on handshakes.
module tb_mul_tile_engine;
    localparam int N = 4;

    typedef struct {
        int              k;
        bit              bias;
        int              mode;
        logic [2:0][63:0] a;
        logic [2:0][31:0] s;
        logic [15:0]     e_const;
        bit              rnd;
        bit              chk;
        logic [15:0]     exp_s;
        logic [15:0]     exp_u;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, start, add_bias;
    logic [15:0] k_len;
    logic        a_valid, s_valid, e_valid, out_ready;
    logic [63:0] a_data, e_data;
    logic [31:0] s_data;
    logic        a_ready_s, s_ready_s, e_ready_s, out_valid_s, busy_s, done_s;
    logic        a_ready_u, s_ready_u, e_ready_u, out_valid_u, busy_u, done_u;
    logic [63:0] out_data_s, out_data_u;
    logic [1:0]  out_row_s, out_row_u;

    int n_chk = 0;
    int n_fail = 0;
    logic [63:0] q_s[$];
    logic [63:0] q_u[$];
    int          q_r[$];
    vec_t        tbl[8];

    always #5 clk = ~clk;

    mul_tile_engine #(.DATA_WIDTH(16), .SYSTOLIC_WIDTH(4), .KW(16), .LOGQ(15), .SECRET_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .add_bias(add_bias),
        .a_valid(a_valid), .a_ready(a_ready_s), .a_data(a_data),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data),
        .e_valid(e_valid), .e_ready(e_ready_s), .e_data(e_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s), .out_row(out_row_s),
        .busy(busy_s), .done(done_s));

    mul_tile_engine #(.DATA_WIDTH(16), .SYSTOLIC_WIDTH(4), .KW(16), .LOGQ(16), .SECRET_SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .add_bias(add_bias),
        .a_valid(a_valid), .a_ready(a_ready_u), .a_data(a_data),
        .s_valid(s_valid), .s_ready(s_ready_u), .s_data(s_data),
        .e_valid(e_valid), .e_ready(e_ready_u), .e_data(e_data),
        .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u), .out_row(out_row_u),
        .busy(busy_u), .done(done_u));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int k, input bit bias, input int mode,
                                input logic [63:0] a0, input logic [63:0] a1, input logic [31:0] s0,
                                input logic [31:0] s1, input logic [15:0] ec, input bit rnd,
                                input bit c, input logic [15:0] xs, input logic [15:0] xu);
        vec_t v;
        v.k = k; v.bias = bias; v.mode = mode;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = 64'h0;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = 32'h0;
        v.e_const = ec; v.rnd = rnd; v.chk = c; v.exp_s = xs; v.exp_u = xu;
        return v;
    endfunction

    function automatic logic [63:0] model_row(input vec_t v, input logic [63:0] erow, input int r,
                                              input bit sgn, input int logq);
        logic [63:0] res;
        res = '0;
        for (int j = 0; j < N; j++) begin
            logic [15:0] sum;
            longint ai, sv, p;
            logic [7:0] sb;
            sum = 16'h0;
            for (int b = 0; b < v.k; b++) begin
                ai = longint'(v.a[b][r*16 +: 16]);
                sb = v.s[b][j*8 +: 8];
                sv = sgn ? longint'($signed(sb)) : longint'(sb);
                p = ai * sv;
                sum = sum + 16'(p);
            end
            if (v.bias) sum = sum + erow[j*16 +: 16];
            res[j*16 +: 16] = sum & 16'((32'd1 << logq) - 32'd1);
        end
        return res;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_s, 0);
        chk({tag, "_a_ready"}, a_ready_s, 0);
        chk({tag, "_s_ready"}, s_ready_s, 0);
        chk({tag, "_e_ready"}, e_ready_s, 0);
        chk({tag, "_out_valid"}, out_valid_s, 0);
        chk({tag, "_done"}, done_s, 0);
        chk({tag, "_out_data"}, out_data_s, 0);
        chk({tag, "_out_row"}, out_row_s, 0);
        chk({tag, "_u_busy"}, busy_u, 0);
        chk({tag, "_u_out_data"}, out_data_u, 0);
    endtask

    task automatic run_tile(input vec_t v);
        logic [3:0][63:0] erow;
        logic [63:0] es, eu, held_data;
        logic [1:0]  held_row;
        logic [15:0] first_s, first_u;
        int beat, er, cyc, rows;
        bit seen_done, saw_a_ready, hold, have_beat;
        if (v.rnd) begin
            for (int b = 0; b < 3; b++) begin
                v.a[b] = {$urandom, $urandom};
                v.s[b] = $urandom;
            end
        end
        for (int r = 0; r < N; r++) erow[r] = v.rnd ? {$urandom, $urandom} : {4{v.e_const}};
        for (int r = 0; r < N; r++) begin
            q_s.push_back(model_row(v, erow[r], r, 1'b1, 15));
            q_u.push_back(model_row(v, erow[r], r, 1'b0, 16));
            q_r.push_back(r);
        end
        @(negedge clk);
        start = 1'b1; k_len = 16'(v.k); add_bias = v.bias;
        a_valid = 1'b0; s_valid = 1'b0; e_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        beat = 0; er = 0; cyc = 0; rows = 0; seen_done = 0; saw_a_ready = 0; hold = 0;
        first_s = '0; first_u = '0; held_data = '0; held_row = '0;
        while (!seen_done && cyc < 400) begin
            cyc++;
            have_beat = (beat < v.k);
            case (v.mode)
                1: begin
                    a_valid = have_beat; s_valid = have_beat && (cyc % 3 == 0);
                    e_valid = v.bias && er < N && cyc[0]; out_ready = 1'b1;
                end
                2: begin
                    a_valid = have_beat; s_valid = have_beat;
                    e_valid = v.bias && er < N && cyc[0];
                    out_ready = !(cyc >= v.k + 3 && cyc < v.k + 6);
                end
                3: begin
                    a_valid = have_beat && ($urandom_range(0, 1) == 1);
                    s_valid = have_beat && ($urandom_range(0, 1) == 1);
                    e_valid = v.bias && er < N && ($urandom_range(0, 1) == 1);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                default: begin
                    a_valid = have_beat; s_valid = have_beat;
                    e_valid = v.bias && er < N; out_ready = 1'b1;
                end
            endcase
            a_data = have_beat ? v.a[beat] : {$urandom, $urandom};
            s_data = have_beat ? v.s[beat] : $urandom;
            e_data = (er < N) ? erow[er] : {$urandom, $urandom};
            #1;
            if (a_ready_s) saw_a_ready = 1;
            if (done_s) begin
                seen_done = 1;
            end else begin
                if (hold) begin
                    chk("hold_data", out_data_s, held_data);
                    chk("hold_row", out_row_s, held_row);
                end
                if (e_ready_s)
                    chk("e_ready_only_on_load", {e_valid, !out_valid_s || out_ready, add_bias}, 3'b111);
                if (a_valid && s_valid && a_ready_s) beat++;
                if (e_valid && e_ready_s) er++;
                if (out_valid_s && out_ready) begin
                    if (q_s.size() == 0) begin
                        chk("extra_row", 1, 0);
                    end else begin
                        es = q_s.pop_front(); eu = q_u.pop_front();
                        chk("row_s", out_data_s, es);
                        chk("row_u", out_data_u, eu);
                        chk("out_row", out_row_s, q_r.pop_front());
                        chk("u_valid", out_valid_u, 1);
                        if (rows == 0) begin
                            first_s = out_data_s[15:0];
                            first_u = out_data_u[15:0];
                        end
                        rows++;
                    end
                end
                hold = out_valid_s && !out_ready;
                held_data = out_data_s;
                held_row = out_row_s;
                @(negedge clk);
            end
        end
        chk("done_seen", seen_done, 1);
        chk("idle_after_done", busy_s, 0);
        chk("rows_drained", rows, N);
        chk("beats_taken", beat, v.k);
        if (v.bias) chk("e_rows_taken", er, N);
        if (v.k == 0) chk("a_ready_never", saw_a_ready, 0);
        if (v.mode == 0) chk("latency", cyc, v.k + N + 2);
        if (v.chk) begin
            chk("row0_lane0_s", first_s, v.exp_s);
            chk("row0_lane0_u", first_u, v.exp_u);
        end
        if (!seen_done) begin
            q_s.delete(); q_u.delete(); q_r.delete();
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic reset_abort();
        @(negedge clk);
        start = 1'b1; k_len = 16'd3; add_bias = 1'b0;
        @(negedge clk);
        start = 1'b0;
        a_valid = 1'b1; s_valid = 1'b1;
        a_data = 64'h1111_2222_3333_4444; s_data = 32'h0505_0505;
        @(negedge clk);
        a_valid = 1'b0; s_valid = 1'b0;
        #1;
        chk("abort_busy", busy_s, 1);
        chk("abort_a_ready", a_ready_s, 1);
        rst_n = 1'b0;
        #1;
        chk_zero("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0; add_bias = 1'b0;
        a_valid = 1'b0; s_valid = 1'b0; e_valid = 1'b0; out_ready = 1'b0;
        a_data = '0; s_data = '0; e_data = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = mk(1, 0, 0, 64'h0004_0003_0002_0001, 64'h0, 32'h0101_0101, 32'h0, 16'h0, 0, 1, 16'h0001, 16'h0001);
        tbl[1] = mk(1, 0, 0, 64'h0000_0000_0000_0005, 64'h0, 32'h0000_00FF, 32'h0, 16'h0, 0, 1, 16'h7FFB, 16'h04FB);
        tbl[2] = mk(0, 1, 0, 64'h0, 64'h0, 32'h0, 32'h0, 16'h0007, 0, 1, 16'h0007, 16'h0007);
        tbl[3] = mk(2, 1, 2, 64'h0, 64'h0, 32'h0, 32'h0, 16'h0, 1, 0, 16'h0, 16'h0);
        tbl[4] = mk(2, 0, 1, 64'h0000_0000_0000_7FFF, 64'h0000_0000_0000_7FFF, 32'h0000_0001, 32'h0000_0001,
                    16'h0, 0, 1, 16'h7FFE, 16'hFFFE);
        tbl[5] = mk(1, 0, 0, 64'h0000_0000_0000_0002, 64'h0, 32'h0000_0003, 32'h0, 16'h0, 0, 1, 16'h0006, 16'h0006);
        tbl[6] = mk(3, 1, 3, 64'h0, 64'h0, 32'h0, 32'h0, 16'h0, 1, 0, 16'h0, 16'h0);
        tbl[7] = mk(3, 1, 0, 64'h0, 64'h0, 32'h0, 32'h0, 16'h0, 1, 0, 16'h0, 16'h0);

        for (int t = 0; t < 8; t++) begin
            if (t == 5) reset_abort();
            run_tile(tbl[t]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
